regfile_2r1w: RTL and testbench

Parametrised register file with one synchronous write port and two independent combinational read ports, replacing the single-read, fixed 8x16 register file in the datapath. Adds synchronous reset of all registers, per-register written flags, optional write-to-read bypass and an optional hardwired-zero R0. Sits between the writeback mux (data_in) and the A/B operand registers feeding the shifter/ALU.

---
 rtl/regfile_2r1w.sv | 106 ++++++++++
 tb/tb_regfile_2r1w.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//
// Register file with one synchronous write port and two independent
// combinational read ports. It sits between the writeback mux (data_in) and
// the A/B operand registers that feed the shifter/ALU.
//
// Each register has a "written since reset" flag, which is reported on
// valid_a / valid_b. The BYPASS parameter lets a read of the register being
// written this cycle see the incoming data_in. The ZERO_R0 parameter
// hardwires R0 to zero.
//
// Parameters
//   WIDTH    data width of each register
//   DEPTH    number of registers; must be a power of 2 and >= 2
//   BYPASS   1: a read of the index being written returns data_in
//   ZERO_R0  1: R0 always reads 0 with valid=1, and writes to R0 are dropped
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears every register and flag
//   data_in     write data
//   writenum    write register index
//   write       write enable
//   readnum_a   read port A index
//   readnum_b   read port B index
//   data_out_a  read port A data
//   data_out_b  read port B data
//   valid_a     register at readnum_a has been written since reset
//   valid_b     register at readnum_b has been written since reset
// -----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    writenum,
    input  logic             write,
    input  logic [AW-1:0]    readnum_a,
    input  logic [AW-1:0]    readnum_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    output logic             valid_a,
    output logic             valid_b
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] written;

    // A write to R0 is discarded when R0 is hardwired, so R0 stays at its
    // reset value. The read path masks R0 anyway; keeping the storage at
    // zero means the stored copy never disagrees with what is read.
    logic wr_en;
    assign wr_en = write && !((ZERO_R0 != 0) && (writenum == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            written <= '0;
        end else if (wr_en) begin
            regs[writenum]    <= data_in;
            written[writenum] <= 1'b1;
        end
    end

    // The bypass is live only while a write will actually land on the next
    // edge. It is therefore suppressed during reset and for a hardwired R0,
    // which wr_en already excludes.
    logic byp_live;
    assign byp_live = (BYPASS != 0) && wr_en && !reset;

    // Returns {valid, data} for one read port. Priority order:
    // hardwired R0, then the bypass, then the stored contents.
    function automatic logic [WIDTH:0] read_port(
        input logic [AW-1:0]    idx,
        input logic [WIDTH-1:0] stored,
        input logic             stored_vld,
        input logic             byp,
        input logic [AW-1:0]    wr_idx,
        input logic [WIDTH-1:0] wr_data
    );
        logic [WIDTH:0] res;
        res = {stored_vld, stored};
        if ((ZERO_R0 != 0) && (idx == '0)) begin
            res = {1'b1, {WIDTH{1'b0}}};
        end else if (byp && (wr_idx == idx)) begin
            res = {1'b1, wr_data};
        end
        return res;
    endfunction

    always_comb begin
        {valid_a, data_out_a} = read_port(readnum_a, regs[readnum_a], written[readnum_a],
                                          byp_live, writenum, data_in);
        {valid_b, data_out_b} = read_port(readnum_b, regs[readnum_b], written[readnum_b],
                                          byp_live, writenum, data_in);
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
//
// Four instances share the stimulus:
//   u_byp  : 16x8, BYPASS=1, ZERO_R0=0
//   u_nbyp : 16x8, BYPASS=0, ZERO_R0=0
//   u_zero : 16x8, BYPASS=1, ZERO_R0=1
//   u_wide : 32x16, BYPASS=1, ZERO_R0=0 (separate stimulus)
//
// Expected values are pushed into a scoreboard queue when stimulus is
// driven, then popped and compared once the combinational outputs settle.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16x8 stimulus
    logic        rst;
    logic [15:0] din;
    logic [2:0]  wn;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        wr;

    logic [15:0] oa0, ob0, oa1, ob1, oa2, ob2;
    logic        va0, vb0, va1, vb1, va2, vb2;

    // 32x16 stimulus
    logic        rst_w;
    logic [31:0] din_w;
    logic [3:0]  wn_w;
    logic [3:0]  ra_w;
    logic [3:0]  rb_w;
    logic        wr_w;
    logic [31:0] oa3, ob3;
    logic        va3, vb3;

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_R0(0)) u_byp (
        .clk(clk), .reset(rst), .data_in(din), .writenum(wn), .write(wr),
        .readnum_a(ra), .readnum_b(rb), .data_out_a(oa0), .data_out_b(ob0),
        .valid_a(va0), .valid_b(vb0));

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(0), .ZERO_R0(0)) u_nbyp (
        .clk(clk), .reset(rst), .data_in(din), .writenum(wn), .write(wr),
        .readnum_a(ra), .readnum_b(rb), .data_out_a(oa1), .data_out_b(ob1),
        .valid_a(va1), .valid_b(vb1));

    regfile_2r1w #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_R0(1)) u_zero (
        .clk(clk), .reset(rst), .data_in(din), .writenum(wn), .write(wr),
        .readnum_a(ra), .readnum_b(rb), .data_out_a(oa2), .data_out_b(ob2),
        .valid_a(va2), .valid_b(vb2));

    regfile_2r1w #(.WIDTH(32), .DEPTH(16), .BYPASS(1), .ZERO_R0(0)) u_wide (
        .clk(clk), .reset(rst_w), .data_in(din_w), .writenum(wn_w), .write(wr_w),
        .readnum_a(ra_w), .readnum_b(rb_w), .data_out_a(oa3), .data_out_b(ob3),
        .valid_a(va3), .valid_b(vb3));

    // ---------------- checking / scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        sb_item_t it;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            it = sb_q.pop_front();
            check_val(it.tag, obs, it.exp);
        end
    endtask

    // ---------------- reference model of stored state (16x8) ----------------
    logic [15:0] m_val [8];
    logic        m_w   [8];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_val[i] = '0;
            m_w[i]   = 1'b0;
        end
    endtask

    task automatic model_write(input int idx, input logic [15:0] val);
        m_val[idx] = val;
        m_w[idx]   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stored-path readback of all 8 registers on every 16-bit instance.
    // write must be 0 here, so there is no bypass contribution.
    task automatic chk_model(input string tag);
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i);
            rb = 3'(7 - i);
            sb_push($sformatf("%s_nbyp_a%0d", tag, i), {16'h0, m_val[i]});
            sb_push($sformatf("%s_nbyp_va%0d", tag, i), {31'h0, m_w[i]});
            sb_push($sformatf("%s_nbyp_b%0d", tag, 7 - i), {16'h0, m_val[7 - i]});
            sb_push($sformatf("%s_nbyp_vb%0d", tag, 7 - i), {31'h0, m_w[7 - i]});
            sb_push($sformatf("%s_byp_a%0d", tag, i), {16'h0, m_val[i]});
            sb_push($sformatf("%s_zero_a%0d", tag, i), (i == 0) ? 32'h0 : {16'h0, m_val[i]});
            sb_push($sformatf("%s_zero_va%0d", tag, i), (i == 0) ? 32'h1 : {31'h0, m_w[i]});
            #1;
            sb_pop({16'h0, oa1});
            sb_pop({31'h0, va1});
            sb_pop({16'h0, ob1});
            sb_pop({31'h0, vb1});
            sb_pop({16'h0, oa0});
            sb_pop({16'h0, oa2});
            sb_pop({31'h0, va2});
        end
    endtask

    task automatic do_write(input int idx, input logic [15:0] val);
        wr  = 1'b1;
        wn  = 3'(idx);
        din = val;
        tick();
        model_write(idx, val);
        wr  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; wr = 1'b0; din = '0; wn = '0; ra = '0; rb = '0;
        rst_w = 1'b1; wr_w = 1'b0; din_w = '0; wn_w = '0; ra_w = '0; rb_w = '0;
        model_reset();
        tick();
        tick();

        // R0 of the hardwired instance reads valid even while reset is held
        ra = 3'd0; #1;
        sb_push("zero_r0_in_reset_va", 32'h1);
        sb_push("zero_r0_in_reset_d", 32'h0);
        sb_pop({31'h0, va2});
        sb_pop({16'h0, oa2});

        rst = 1'b0;
        rst_w = 1'b0;
        #1;
        chk_model("rst");

        // Reset overrides a same-cycle write
        do_write(3, 16'hBEEF);
        rst = 1'b1; wr = 1'b1; wn = 3'd3; din = 16'h1234; ra = 3'd3;
        #2;
        sb_push("rst_byp_suppressed_d", 32'hBEEF);
        sb_push("rst_byp_suppressed_v", 32'h1);
        sb_pop({16'h0, oa0});
        sb_pop({31'h0, va0});
        tick();
        model_reset();
        rst = 1'b0; wr = 1'b0;
        #2;
        sb_push("rst_clear_byp_d", 32'h0);
        sb_push("rst_clear_byp_v", 32'h0);
        sb_push("rst_clear_nbyp_d", 32'h0);
        sb_pop({16'h0, oa0});
        sb_pop({31'h0, va0});
        sb_pop({16'h0, oa1});

        // Dual independent reads
        do_write(2, 16'h00A5);
        do_write(5, 16'h5A00);
        ra = 3'd2; rb = 3'd5; #2;
        sb_push("dual_a", 32'h00A5);
        sb_push("dual_b", 32'h5A00);
        sb_push("dual_va", 32'h1);
        sb_push("dual_vb", 32'h1);
        sb_pop({16'h0, oa0});
        sb_pop({16'h0, ob0});
        sb_pop({31'h0, va0});
        sb_pop({31'h0, vb0});
        ra = 3'd5; #2;
        sb_push("same_a", 32'h5A00);
        sb_push("same_b", 32'h5A00);
        sb_pop({16'h0, oa1});
        sb_pop({16'h0, ob1});

        // Bypass versus stored read of the register being written
        do_write(4, 16'h1111);
        wr = 1'b1; wn = 3'd4; din = 16'h2222; ra = 3'd4; #2;
        sb_push("byp_pre_edge", 32'h2222);
        sb_push("nbyp_pre_edge", 32'h1111);
        sb_pop({16'h0, oa0});
        sb_pop({16'h0, oa1});
        tick();
        model_write(4, 16'h2222);
        wr = 1'b0; #2;
        sb_push("byp_post_edge", 32'h2222);
        sb_push("nbyp_post_edge", 32'h2222);
        sb_pop({16'h0, oa0});
        sb_pop({16'h0, oa1});

        // Bypass to a never-written register sets valid on both ports
        wr = 1'b1; wn = 3'd6; din = 16'h0606; ra = 3'd6; rb = 3'd6; #2;
        sb_push("byp_unwr_va", 32'h1);
        sb_push("byp_unwr_vb", 32'h1);
        sb_push("byp_unwr_b", 32'h0606);
        sb_push("nbyp_unwr_va", 32'h0);
        sb_push("nbyp_unwr_a", 32'h0);
        sb_pop({31'h0, va0});
        sb_pop({31'h0, vb0});
        sb_pop({16'h0, ob0});
        sb_pop({31'h0, va1});
        sb_pop({16'h0, oa1});
        tick();
        model_write(6, 16'h0606);
        wr = 1'b0;

        // Writes to a hardwired R0 are ignored and never bypassed
        wr = 1'b1; wn = 3'd0; din = 16'hFFFF; ra = 3'd0; #2;
        sb_push("zero_pre_d", 32'h0);
        sb_push("zero_pre_v", 32'h1);
        sb_push("byp_r0_pre_d", 32'hFFFF);
        sb_push("nbyp_r0_pre_v", 32'h0);
        sb_pop({16'h0, oa2});
        sb_pop({31'h0, va2});
        sb_pop({16'h0, oa0});
        sb_pop({31'h0, va1});
        tick();
        model_write(0, 16'hFFFF);
        wr = 1'b0; #2;
        sb_push("zero_post_d", 32'h0);
        sb_push("zero_post_v", 32'h1);
        sb_push("nbyp_r0_post_d", 32'hFFFF);
        sb_pop({16'h0, oa2});
        sb_pop({31'h0, va2});
        sb_pop({16'h0, oa1});

        // Back-to-back writes to one index: the last one wins
        wr = 1'b1; wn = 3'd7; din = 16'hAAAA; ra = 3'd7; #2;
        sb_push("b2b1_byp", 32'hAAAA);
        sb_push("b2b1_nbyp", 32'h0);
        sb_pop({16'h0, oa0});
        sb_pop({16'h0, oa1});
        tick();
        model_write(7, 16'hAAAA);
        din = 16'h5555; #2;
        sb_push("b2b2_byp", 32'h5555);
        sb_push("b2b2_nbyp", 32'hAAAA);
        sb_pop({16'h0, oa0});
        sb_pop({16'h0, oa1});
        tick();
        model_write(7, 16'h5555);
        wr = 1'b0;
        #1;
        chk_model("b2b");

        // Hold: write low while index and data wander
        for (int c = 0; c < 10; c++) begin
            wn  = 3'($urandom_range(0, 7));
            din = 16'($urandom);
            tick();
        end
        chk_model("hold");

        // Reset mid-sequence with write high: everything is lost
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            wr  = 1'b1;
            wn  = 3'($urandom_range(0, 7));
            din = 16'($urandom);
            tick();
        end
        model_reset();
        rst = 1'b0; wr = 1'b0;
        #1;
        chk_model("rst2");

        // 32x16: fresh-reset contents, then write and read back everything
        for (int i = 0; i < 16; i++) begin
            ra_w = 4'(i);
            rb_w = 4'(15 - i);
            sb_push($sformatf("wide_rst_a%0d", i), 32'h0);
            sb_push($sformatf("wide_rst_va%0d", i), 32'h0);
            sb_push($sformatf("wide_rst_b%0d", 15 - i), 32'h0);
            sb_push($sformatf("wide_rst_vb%0d", 15 - i), 32'h0);
            #1;
            sb_pop(oa3);
            sb_pop({31'h0, va3});
            sb_pop(ob3);
            sb_pop({31'h0, vb3});
        end
        for (int i = 0; i < 16; i++) begin
            wr_w  = 1'b1;
            wn_w  = 4'(i);
            din_w = 32'(i) * 32'h0101_0101;
            tick();
        end
        wr_w = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ra_w = 4'(i);
            rb_w = 4'(15 - i);
            sb_push($sformatf("wide_a%0d", i), 32'(i) * 32'h0101_0101);
            sb_push($sformatf("wide_va%0d", i), 32'h1);
            sb_push($sformatf("wide_b%0d", 15 - i), 32'(15 - i) * 32'h0101_0101);
            sb_push($sformatf("wide_vb%0d", 15 - i), 32'h1);
            #1;
            sb_pop(oa3);
            sb_pop({31'h0, va3});
            sb_pop(ob3);
            sb_pop({31'h0, vb3});
        end

        check_val("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
